sp_ram_pipe: RTL and testbench
==============================

Name: sp_ram_pipe

Overview:
Parametrised successor to the team's single-port byte-enabled SRAM model. Adds generic data width and depth, and a valid/ready request handshake. Adds an optional output pipeline register and a post-reset zero-initialisation sequencer. Sits between the core/bus adapters and instruction/data storage wherever deterministic memory contents and a registered read path are required.

Parameters:
DATA_WIDTH, 32, word width in bits; must be a multiple of 8.
NUM_WORDS, 256, depth in words.
ADDR_WIDTH, 8, address width; must be at least clog2(NUM_WORDS).
OUT_REG, 0, 0 = read latency 1 cycle; 1 = extra output register, read latency 2 cycles.
INIT_ZERO, 1, 1 = clear every word after reset before accepting requests; 0 = no init.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset; one clock, reset asynchronous active-low
req_valid_i  in  1  request valid
req_ready_o  out  1  request accepted this cycle when valid and ready are both high
we_i  in  1  1 = write, 0 = read
addr_i  in  ADDR_WIDTH  word address
wdata_i  in  DATA_WIDTH  write data
be_i  in  DATA_WIDTH/8  byte enables; bit k covers wdata_i[8k+7:8k]
rvalid_o  out  1  read data valid, one-cycle pulse per accepted read
rdata_o  out  DATA_WIDTH  read data
init_done_o  out  1  high once initialisation is complete

Behaviour:
- Reset (rst_n low, asynchronous): req_ready_o=0, rvalid_o=0, rdata_o=0, init_done_o=0, FSM enters INIT (or RUN if INIT_ZERO=0), init counter=0. Memory array is not reset.
- FSM INIT, used only when INIT_ZERO=1:
  - One word written to 0 per cycle, address 0..NUM_WORDS-1 ascending.
  - req_ready_o=0 throughout; requests are ignored.
  - After the write to NUM_WORDS-1, FSM goes to RUN. init_done_o and req_ready_o rise on the following cycle, so the first request is accepted NUM_WORDS+1 cycles after reset release.
- With INIT_ZERO=0: RUN is entered directly; req_ready_o=1 and init_done_o=1 from the first clk edge after reset release.
- Reset asserted during INIT aborts the sequence. On release, INIT restarts from address 0.
- FSM RUN: req_ready_o=1 constantly; no backpressure on the response path.
- Accepted write:
  - Bytes with be_i[k]=1 are updated at that clock edge; other bytes are unchanged.
  - be_i=0 writes nothing.
  - No rvalid_o pulse.
- Accepted read:
  - Word at addr_i is sampled at the acceptance edge.
  - rvalid_o=1 and rdata_o=word for exactly one cycle, 1 cycle (OUT_REG=0) or 2 cycles (OUT_REG=1) after acceptance.
  - be_i is ignored on reads.
- Back-to-back: one request per cycle, fully pipelined. A read accepted the cycle after a write to the same address returns the new data.
- rdata_o holds its last value while rvalid_o=0. It is not cleared between responses.
- Out of range (addr_i >= NUM_WORDS): write is dropped and no storage changes; read still produces rvalid_o with rdata_o=0.
- req_valid_i=0: no state change, no response.

Test Plan:
- Reset release with INIT_ZERO=1, NUM_WORDS=256 -> req_ready_o=0 and init_done_o=0 for 256 cycles, both 1 on cycle 257; a read of addr 0x7F returns 0x00000000.
- Write addr 5, data 0xDEADBEEF, be 4'b1111; then write addr 5, data 0x11223344, be 4'b0101; then read addr 5 -> rdata_o=0xDE22BE44, rvalid_o pulses 1 cycle after the read (OUT_REG=0) / 2 cycles after (OUT_REG=1).
- Back-to-back reads of addr 1,2,3 holding words 0xA,0xB,0xC, OUT_REG=1 -> rvalid_o high for 3 consecutive cycles starting 2 cycles after the first request, data 0xA,0xB,0xC in order.
- Write then immediate read of the same addr 9 with 0x5A5A5A5A -> read returns 0x5A5A5A5A; write to addr 300 with NUM_WORDS=256, ADDR_WIDTH=9 -> no word changed, read of addr 300 returns 0 with rvalid_o.
- Assert rst_n low at init address 100, release -> init restarts at 0; ready rises NUM_WORDS+1 cycles after the second release; no rvalid_o during init even with req_valid_i held high.
- DATA_WIDTH=64, NUM_WORDS=1024, ADDR_WIDTH=10, INIT_ZERO=0 -> ready one cycle after reset release; byte enable 8'h80 writes only bits 63:56.

Source files
------------

// File: rtl/sp_ram_pipe.sv
// Single-port byte-enabled RAM with valid/ready requests, optional output register
// and a post-reset zero-fill sequencer.
module sp_ram_pipe #(
   parameter int DATA_WIDTH = 32,
   parameter int NUM_WORDS  = 256,
   parameter int ADDR_WIDTH = 8,
   parameter int OUT_REG    = 0,
   parameter int INIT_ZERO  = 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    req_valid_i,
   output logic                    req_ready_o,
   input  logic                    we_i,
   input  logic [ADDR_WIDTH-1:0]   addr_i,
   input  logic [DATA_WIDTH-1:0]   wdata_i,
   input  logic [DATA_WIDTH/8-1:0] be_i,
   output logic                    rvalid_o,
   output logic [DATA_WIDTH-1:0]   rdata_o,
   output logic                    init_done_o
);

   localparam int NUM_BYTES = DATA_WIDTH / 8;
   localparam int IDX_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

   typedef enum logic {ST_INIT, ST_RUN} state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [IDX_W-1:0]      r_init_cnt;
   logic                  w_init_last;
   logic                  w_init_we;
   logic                  w_ready_nxt;
   logic                  r_ready;
   logic                  w_accept;
   logic                  w_in_range;
   logic [IDX_W-1:0]      w_idx;
   logic                  r_rvalid1;
   logic [DATA_WIDTH-1:0] r_rdata1;
   logic [DATA_WIDTH-1:0] r_mem [NUM_WORDS];

   assign w_init_last = (r_init_cnt == IDX_W'(NUM_WORDS - 1));
   assign w_accept    = req_valid_i & r_ready;
   assign w_in_range  = (32'(addr_i) < 32'(NUM_WORDS));
   assign w_idx       = addr_i[IDX_W-1:0];

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process ordering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= (INIT_ZERO != 0) ? ST_INIT : ST_RUN;
         r_init_cnt <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (r_state == ST_INIT) begin
            r_init_cnt <= r_init_cnt + 1'b1;
         end
      end
   end

   // NOTE: defaults at the top of each always_comb keep it free of latches.
   always_comb begin
      w_state_nxt = r_state;
      if (r_state == ST_INIT && w_init_last) begin
         w_state_nxt = ST_RUN;
      end
   end

   always_comb begin
      w_init_we   = (r_state == ST_INIT);
      w_ready_nxt = (w_state_nxt == ST_RUN);
   end

   // Ready is registered so it rises one cycle after the final init write.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ready <= 1'b0;
      end else begin
         r_ready <= w_ready_nxt;
      end
   end

   assign req_ready_o = r_ready;
   assign init_done_o = r_ready;

   // NOTE: the storage array has no reset; deterministic contents come from
   // the zero-fill sequencer instead.
   always_ff @(posedge clk) begin
      if (w_init_we) begin
         r_mem[r_init_cnt] <= '0;
      end else if (w_accept && we_i && w_in_range) begin
         for (int k = 0; k < NUM_BYTES; k++) begin
            if (be_i[k]) begin
               r_mem[w_idx][8*k +: 8] <= wdata_i[8*k +: 8];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rvalid1 <= 1'b0;
         r_rdata1  <= '0;
      end else begin
         r_rvalid1 <= w_accept & ~we_i;
         if (w_accept && !we_i) begin
            r_rdata1 <= w_in_range ? r_mem[w_idx] : '0;
         end
      end
   end

   if (OUT_REG != 0) begin : g_out_reg
      logic                  r_rvalid2;
      logic [DATA_WIDTH-1:0] r_rdata2;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_rvalid2 <= 1'b0;
            r_rdata2  <= '0;
         end else begin
            r_rvalid2 <= r_rvalid1;
            if (r_rvalid1) begin
               r_rdata2 <= r_rdata1;
            end
         end
      end

      assign rvalid_o = r_rvalid2;
      assign rdata_o  = r_rdata2;
   end else begin : g_no_out_reg
      assign rvalid_o = r_rvalid1;
      assign rdata_o  = r_rdata1;
   end

endmodule

// File: tb/tb_sp_ram_pipe.sv
// Directed bench for sp_ram_pipe: two 32-bit instances sharing one request bus
// (OUT_REG 0 and 1, with init) plus a 64-bit instance without init.
module tb_sp_ram_pipe;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic        a_valid, a_we;
   logic [8:0]  a_addr;
   logic [31:0] a_wdata;
   logic [3:0]  a_be;
   logic        a0_ready, a0_done, a0_rvalid;
   logic [31:0] a0_rdata;
   logic        a1_ready, a1_done, a1_rvalid;
   logic [31:0] a1_rdata;

   logic        d_valid, d_we;
   logic [9:0]  d_addr;
   logic [63:0] d_wdata;
   logic [7:0]  d_be;
   logic        d_ready, d_done, d_rvalid;
   logic [63:0] d_rdata;

   int n_checks = 0;
   int n_fail   = 0;

   sp_ram_pipe #(.DATA_WIDTH(32), .NUM_WORDS(256), .ADDR_WIDTH(9), .OUT_REG(0), .INIT_ZERO(1)) u_ram0 (
      .clk(clk), .rst_n(rst_n), .req_valid_i(a_valid), .req_ready_o(a0_ready), .we_i(a_we),
      .addr_i(a_addr), .wdata_i(a_wdata), .be_i(a_be), .rvalid_o(a0_rvalid), .rdata_o(a0_rdata),
      .init_done_o(a0_done));

   sp_ram_pipe #(.DATA_WIDTH(32), .NUM_WORDS(256), .ADDR_WIDTH(9), .OUT_REG(1), .INIT_ZERO(1)) u_ram1 (
      .clk(clk), .rst_n(rst_n), .req_valid_i(a_valid), .req_ready_o(a1_ready), .we_i(a_we),
      .addr_i(a_addr), .wdata_i(a_wdata), .be_i(a_be), .rvalid_o(a1_rvalid), .rdata_o(a1_rdata),
      .init_done_o(a1_done));

   sp_ram_pipe #(.DATA_WIDTH(64), .NUM_WORDS(1024), .ADDR_WIDTH(10), .OUT_REG(0), .INIT_ZERO(0)) u_ram2 (
      .clk(clk), .rst_n(rst_n), .req_valid_i(d_valid), .req_ready_o(d_ready), .we_i(d_we),
      .addr_i(d_addr), .wdata_i(d_wdata), .be_i(d_be), .rvalid_o(d_rvalid), .rdata_o(d_rdata),
      .init_done_o(d_done));

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic a_req(input logic we, input logic [8:0] addr, input logic [31:0] data,
                        input logic [3:0] be);
      a_valid = 1'b1; a_we = we; a_addr = addr; a_wdata = data; a_be = be;
      tick();
      a_valid = 1'b0; a_we = 1'b0;
   endtask

   // Read on the shared bus; latency 1 on u_ram0, latency 2 on u_ram1.
   task automatic a_read(input string tag, input logic [8:0] addr, input logic [31:0] exp);
      a_req(1'b0, addr, 32'h0, 4'hF);
      check({tag, " rvalid0"}, 64'(a0_rvalid), 64'd1);
      check({tag, " rdata0"}, 64'(a0_rdata), 64'(exp));
      check({tag, " rvalid1 early"}, 64'(a1_rvalid), 64'd0);
      tick();
      check({tag, " rvalid0 pulse"}, 64'(a0_rvalid), 64'd0);
      check({tag, " rvalid1"}, 64'(a1_rvalid), 64'd1);
      check({tag, " rdata1"}, 64'(a1_rdata), 64'(exp));
   endtask

   task automatic d_req(input logic we, input logic [9:0] addr, input logic [63:0] data,
                        input logic [7:0] be);
      d_valid = 1'b1; d_we = we; d_addr = addr; d_wdata = data; d_be = be;
      tick();
      d_valid = 1'b0; d_we = 1'b0;
   endtask

   task automatic d_read(input string tag, input logic [9:0] addr, input logic [63:0] exp);
      d_req(1'b0, addr, 64'h0, 8'h00);
      check({tag, " rvalid"}, 64'(d_rvalid), 64'd1);
      check({tag, " rdata"}, d_rdata, exp);
      tick();
      check({tag, " rvalid pulse"}, 64'(d_rvalid), 64'd0);
   endtask

   // Called at a negedge right after reset release; requests held high throughout.
   task automatic wait_ready(input string tag);
      int cyc  = 0;
      bit seen = 1'b0;
      a_valid = 1'b1; a_we = 1'b0; a_addr = 9'h000;
      check({tag, " ready at release"}, 64'(a0_ready), 64'd0);
      check({tag, " u2 ready at release"}, 64'(d_ready), 64'd0);
      while (a0_ready !== 1'b1 && cyc < 400) begin
         tick();
         cyc++;
         if (a0_rvalid || a1_rvalid) seen = 1'b1;
         if (cyc == 1) check({tag, " u2 ready 1 cycle"}, 64'(d_ready), 64'd1);
         if (cyc == 255) check({tag, " done low"}, 64'(a0_done), 64'd0);
      end
      a_valid = 1'b0;
      check({tag, " ready latency"}, 64'(cyc), 64'd256);
      check({tag, " done0"}, 64'(a0_done), 64'd1);
      check({tag, " ready1"}, 64'(a1_ready), 64'd1);
      check({tag, " done1"}, 64'(a1_done), 64'd1);
      check({tag, " no rvalid in init"}, 64'(seen), 64'd0);
   endtask

   initial begin
      rst_n = 1'b0;
      a_valid = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0; a_be = '0;
      d_valid = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_be = '0;
      tick();
      tick();
      check("rst ready0", 64'(a0_ready), 64'd0);
      check("rst done0", 64'(a0_done), 64'd0);
      check("rst rvalid0", 64'(a0_rvalid), 64'd0);
      check("rst rdata0", 64'(a0_rdata), 64'd0);
      check("rst rdata1", 64'(a1_rdata), 64'd0);
      check("rst u2 done", 64'(d_done), 64'd0);

      rst_n = 1'b1;
      wait_ready("init1");
      a_read("init 7F", 9'h07F, 32'h0000_0000);

      a_req(1'b1, 9'd5, 32'hDEAD_BEEF, 4'b1111);
      a_req(1'b1, 9'd5, 32'h1122_3344, 4'b0101);
      a_read("be merge", 9'd5, 32'hDE22_BE44);
      a_req(1'b1, 9'd5, 32'hFFFF_FFFF, 4'b0000);
      a_read("be zero", 9'd5, 32'hDE22_BE44);

      a_req(1'b1, 9'd1, 32'h0000_000A, 4'hF);
      a_req(1'b1, 9'd2, 32'h0000_000B, 4'hF);
      a_req(1'b1, 9'd3, 32'h0000_000C, 4'hF);
      a_valid = 1'b1; a_we = 1'b0; a_addr = 9'd1;
      tick();
      check("b2b s1 rv0", 64'(a0_rvalid), 64'd1);
      check("b2b s1 rd0", 64'(a0_rdata), 64'hA);
      check("b2b s1 rv1", 64'(a1_rvalid), 64'd0);
      a_addr = 9'd2;
      tick();
      check("b2b s2 rd0", 64'(a0_rdata), 64'hB);
      check("b2b s2 rv1", 64'(a1_rvalid), 64'd1);
      check("b2b s2 rd1", 64'(a1_rdata), 64'hA);
      a_addr = 9'd3;
      tick();
      check("b2b s3 rd0", 64'(a0_rdata), 64'hC);
      check("b2b s3 rv1", 64'(a1_rvalid), 64'd1);
      check("b2b s3 rd1", 64'(a1_rdata), 64'hB);
      a_valid = 1'b0;
      tick();
      check("b2b s4 rv0", 64'(a0_rvalid), 64'd0);
      check("b2b s4 hold0", 64'(a0_rdata), 64'hC);
      check("b2b s4 rv1", 64'(a1_rvalid), 64'd1);
      check("b2b s4 rd1", 64'(a1_rdata), 64'hC);
      tick();
      check("b2b s5 rv1", 64'(a1_rvalid), 64'd0);
      check("b2b s5 hold1", 64'(a1_rdata), 64'hC);

      a_req(1'b1, 9'd9, 32'h5A5A_5A5A, 4'hF);
      a_read("wr-rd 9", 9'd9, 32'h5A5A_5A5A);

      a_req(1'b1, 9'd300, 32'hFFFF_FFFF, 4'hF);
      a_read("oor 300", 9'd300, 32'h0000_0000);
      a_read("alias 44", 9'd44, 32'h0000_0000);
      a_read("keep 5", 9'd5, 32'hDE22_BE44);
      a_req(1'b1, 9'd255, 32'h1234_5678, 4'hF);
      a_read("top 255", 9'd255, 32'h1234_5678);
      a_read("oor 256", 9'd256, 32'h0000_0000);

      d_req(1'b1, 10'd7, 64'h0123_4567_89AB_CDEF, 8'hFF);
      d_req(1'b1, 10'd7, 64'hFFFF_FFFF_FFFF_FFFF, 8'h80);
      d_read("w64 be80", 10'd7, 64'hFF23_4567_89AB_CDEF);
      d_req(1'b1, 10'd1023, 64'hCAFE_F00D_0BAD_BEEF, 8'hFF);
      d_read("w64 top", 10'd1023, 64'hCAFE_F00D_0BAD_BEEF);

      a_req(1'b1, 9'd150, 32'h1501_5015, 4'hF);
      a_read("pre-abort 150", 9'd150, 32'h1501_5015);
      rst_n = 1'b0;
      tick();
      check("rst2 rdata0", 64'(a0_rdata), 64'd0);
      check("rst2 rdata1", 64'(a1_rdata), 64'd0);
      check("rst2 ready0", 64'(a0_ready), 64'd0);
      check("rst2 u2 ready", 64'(d_ready), 64'd0);
      rst_n = 1'b1;
      a_valid = 1'b1; a_we = 1'b0; a_addr = 9'd0;
      repeat (100) tick();
      check("abort ready0", 64'(a0_ready), 64'd0);
      check("abort rvalid0", 64'(a0_rvalid), 64'd0);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      wait_ready("init2");
      a_read("post-init 150", 9'd150, 32'h0000_0000);
      a_read("post-init 5", 9'd5, 32'h0000_0000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
